// File: rtl/arb_pkg.sv
// Shared arbitration types: grant FSM states and a one-hot to binary index helper.
// Used by the grant controller; arbitration width is bounded by ARB_MAX_N.
package arb_pkg;

  localparam int ARB_MAX_N = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Returns the position of the set bit; a zero vector maps to index 0.
  function automatic int unsigned oh2idx(input logic [ARB_MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter.sv
// Fixed-priority arbiter: grants the lowest-numbered active request.
// Combinational, zero latency; no backpressure.
module arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0] reqs,
  output logic [N-1:0] gnts
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnts = reqs & (~reqs + N'(1));

endmodule

// File: rtl/arb_grant_ctrl.sv
// Round-robin grant controller: one-cycle arbitration latency, grant held until done.
// Grant locks regardless of reqs; one idle bubble between consecutive grants.
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter  int ISIZE = 8,
  localparam int IDXW  = $clog2(ISIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ISIZE-1:0] reqs,
  input  logic             done,
  output logic [ISIZE-1:0] gnts,
  output logic             gnt_vld,
  output logic [IDXW-1:0]  gnt_idx
);

  arb_state_e       state_q, state_d;
  logic [ISIZE-1:0] gnts_q, gnts_d;
  logic             vld_q, vld_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;

  logic [ISIZE-1:0] mask;
  logic [ISIZE-1:0] masked;
  logic [ISIZE-1:0] gnt_masked;
  logic [ISIZE-1:0] gnt_raw;
  logic [ISIZE-1:0] sel;

  // Requesters at or above the pointer get first claim.
  always_comb begin
    mask = '0;
    for (int i = 0; i < ISIZE; i++) begin
      mask[i] = (IDXW'(i) >= ptr_q);
    end
  end

  assign masked = reqs & mask;

  arbiter #(.N(ISIZE)) u_arb_masked (
    .reqs (masked),
    .gnts (gnt_masked)
  );

  arbiter #(.N(ISIZE)) u_arb_raw (
    .reqs (reqs),
    .gnts (gnt_raw)
  );

  assign sel = (|masked) ? gnt_masked : gnt_raw;

  always_comb begin
    state_d = state_q;
    gnts_d  = gnts_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|reqs) begin
          state_d = GRANT;
          gnts_d  = sel;
          vld_d   = 1'b1;
          idx_d   = IDXW'(oh2idx(ARB_MAX_N'(sel)));
        end
      end
      GRANT: begin
        if (done) begin
          state_d = IDLE;
          gnts_d  = '0;
          vld_d   = 1'b0;
          idx_d   = '0;
          ptr_d   = (idx_q == IDXW'(ISIZE - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnts_q  <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnts_q  <= gnts_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnts    = gnts_q;
  assign gnt_vld = vld_q;
  assign gnt_idx = idx_q;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Bench for arb_grant_ctrl: directed vector table, lock/reset sequences, random vs model.
// Also runs a 5-requester instance to exercise non-power-of-two pointer wrap.
module tb_arb_grant_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] reqs;
  logic       done;
  logic [7:0] gnts;
  logic       gnt_vld;
  logic [2:0] gnt_idx;

  logic [4:0] reqs5;
  logic       done5;
  logic [4:0] gnts5;
  logic       gnt_vld5;
  logic [2:0] gnt_idx5;

  int checks   = 0;
  int failures = 0;

  // Reference model state: busy flag, granted requester, round-robin start point.
  bit m8_busy;
  int m8_cur;
  int m8_ptr;
  bit m5_busy;
  int m5_cur;
  int m5_ptr;

  typedef struct {
    bit         pre_rst;
    logic [7:0] reqs;
    logic       done;
    logic [7:0] gnts;
    logic       vld;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs[$];

  arb_grant_ctrl #(.ISIZE(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .reqs    (reqs),
    .done    (done),
    .gnts    (gnts),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  arb_grant_ctrl #(.ISIZE(5)) dut5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .reqs    (reqs5),
    .done    (done5),
    .gnts    (gnts5),
    .gnt_vld (gnt_vld5),
    .gnt_idx (gnt_idx5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Circular search from ptr for the next requester; release moves ptr past the holder.
  task automatic model_edge(input int n, input logic [7:0] r, input logic d,
                            inout bit busy, inout int cur, inout int ptr);
    if (busy) begin
      if (d) begin
        busy = 1'b0;
        ptr  = (cur + 1) % n;
        cur  = 0;
      end
    end else if (r != 8'h00) begin
      for (int j = 0; j < n; j++) begin
        int k;
        k = (ptr + j) % n;
        if (r[k]) begin
          busy = 1'b1;
          cur  = k;
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    m8_busy = 1'b0; m8_cur = 0; m8_ptr = 0;
    m5_busy = 1'b0; m5_cur = 0; m5_ptr = 0;
  endtask

  // Called 1 time unit after a rising edge; leaves the same phase.
  task automatic step(input logic [7:0] r, input logic d, input logic [4:0] r5, input logic d5);
    reqs  = r;
    done  = d;
    reqs5 = r5;
    done5 = d5;
    @(posedge clk);
    model_edge(8, r, d, m8_busy, m8_cur, m8_ptr);
    model_edge(5, {3'b000, r5}, d5, m5_busy, m5_cur, m5_ptr);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input bit pr, input logic [7:0] r, input logic d,
                     input logic [7:0] g, input logic v, input logic [2:0] i);
    vec_t t;
    t.pre_rst = pr; t.reqs = r; t.done = d; t.gnts = g; t.vld = v; t.idx = i;
    vecs.push_back(t);
  endtask

  task automatic chk_out(input string nm, input logic [7:0] g, input logic v, input logic [2:0] i);
    chk({nm, "_gnts"}, 32'(gnts), 32'(g));
    chk({nm, "_vld"}, 32'(gnt_vld), 32'(v));
    chk({nm, "_idx"}, 32'(gnt_idx), 32'(i));
  endtask

  initial begin
    logic [7:0] r;
    logic [4:0] r5;
    logic [31:0] exp_g;

    // Rotation over 8'h1F, each grant followed by one idle cycle.
    add(0, 8'h1F, 0, 8'h01, 1, 3'd0); add(0, 8'h1F, 1, 8'h00, 0, 3'd0);
    add(0, 8'h1F, 0, 8'h02, 1, 3'd1); add(0, 8'h1F, 1, 8'h00, 0, 3'd0);
    add(0, 8'h1F, 0, 8'h04, 1, 3'd2); add(0, 8'h1F, 1, 8'h00, 0, 3'd0);
    add(0, 8'h1F, 0, 8'h08, 1, 3'd3); add(0, 8'h1F, 1, 8'h00, 0, 3'd0);
    add(0, 8'h1F, 0, 8'h10, 1, 3'd4); add(0, 8'h1F, 1, 8'h00, 0, 3'd0);
    add(0, 8'h1F, 0, 8'h01, 1, 3'd0); add(0, 8'h1F, 1, 8'h00, 0, 3'd0);
    // Sparse pattern 8'h3A from ptr 0, wrapping back to requester 1.
    add(1, 8'h3A, 0, 8'h02, 1, 3'd1); add(0, 8'h3A, 1, 8'h00, 0, 3'd0);
    add(0, 8'h3A, 0, 8'h08, 1, 3'd3); add(0, 8'h3A, 1, 8'h00, 0, 3'd0);
    add(0, 8'h3A, 0, 8'h10, 1, 3'd4); add(0, 8'h3A, 1, 8'h00, 0, 3'd0);
    add(0, 8'h3A, 0, 8'h20, 1, 3'd5); add(0, 8'h3A, 1, 8'h00, 0, 3'd0);
    add(0, 8'h3A, 0, 8'h02, 1, 3'd1); add(0, 8'h3A, 1, 8'h00, 0, 3'd0);
    // Grant idx4 leaves ptr=5; 8'h0A has nothing at or above 5, so falls back to lowest.
    add(0, 8'h10, 0, 8'h10, 1, 3'd4); add(0, 8'h10, 1, 8'h00, 0, 3'd0);
    add(0, 8'h0A, 0, 8'h02, 1, 3'd1); add(0, 8'h0A, 1, 8'h00, 0, 3'd0);
    add(0, 8'h0A, 0, 8'h08, 1, 3'd3); add(0, 8'h0A, 1, 8'h00, 0, 3'd0);
    add(0, 8'h00, 1, 8'h00, 0, 3'd0);

    rst_n = 1'b0; reqs = 8'hFF; done = 1'b0; reqs5 = 5'h1F; done5 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 8'h00, 1'b0, 3'd0);
    chk("reset5_gnts", 32'(gnts5), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      if (vecs[n].pre_rst) rst_pulse();
      step(vecs[n].reqs, vecs[n].done, 5'h00, 1'b0);
      chk_out($sformatf("vec%0d", n), vecs[n].gnts, vecs[n].vld, vecs[n].idx);
    end

    // Lock: grant survives its request dropping until done (ptr=4 here).
    step(8'h04, 0, 5'h00, 0);
    chk_out("lock_start", 8'h04, 1'b1, 3'd2);
    for (int c = 0; c < 5; c++) begin
      step(8'h00, 0, 5'h00, 0);
      chk_out($sformatf("lock_hold%0d", c), 8'h04, 1'b1, 3'd2);
    end
    step(8'h00, 1, 5'h00, 0);
    chk_out("lock_release", 8'h00, 1'b0, 3'd0);

    // Asynchronous reset mid-grant with ptr=3 beforehand.
    step(8'h08, 0, 5'h00, 0);
    chk_out("pre_rst_grant", 8'h08, 1'b1, 3'd3);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 1'b0, 3'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(8'h09, 0, 5'h00, 0);
    chk_out("ptr_restart", 8'h01, 1'b1, 3'd0);
    step(8'h00, 1, 5'h00, 0);
    chk_out("rel_after_rst", 8'h00, 1'b0, 3'd0);
    for (int c = 0; c < 3; c++) begin
      step(8'h00, 1, 5'h00, 0);
      chk_out($sformatf("idle_done%0d", c), 8'h00, 1'b0, 3'd0);
    end
    step(8'h03, 0, 5'h00, 0);
    chk_out("ptr_kept", 8'h02, 1'b1, 3'd1);
    step(8'h00, 1, 5'h00, 0);
    step(8'h08, 0, 5'h00, 0);
    chk_out("post_rst_08", 8'h08, 1'b1, 3'd3);

    // Random traffic on both instances against the model.
    rst_pulse();
    for (int c = 0; c < 400; c++) begin
      r  = 8'($urandom) & 8'($urandom);
      r5 = 5'($urandom) & 5'($urandom);
      step(r, ($urandom_range(0, 2) == 0), r5, ($urandom_range(0, 2) == 0));
      exp_g = m8_busy ? (32'd1 << m8_cur) : 32'd0;
      chk($sformatf("rnd%0d_gnts", c), 32'(gnts), exp_g);
      chk($sformatf("rnd%0d_vld", c), 32'(gnt_vld), 32'(m8_busy));
      chk($sformatf("rnd%0d_idx", c), 32'(gnt_idx), 32'(m8_cur));
      chk($sformatf("rnd%0d_onehot", c), 32'($countones(gnts) <= 1), 32'd1);
      exp_g = m5_busy ? (32'd1 << m5_cur) : 32'd0;
      chk($sformatf("rnd5_%0d_gnts", c), 32'(gnts5), exp_g);
      chk($sformatf("rnd5_%0d_vld", c), 32'(gnt_vld5), 32'(m5_busy));
      chk($sformatf("rnd5_%0d_idx", c), 32'(gnt_idx5), 32'(m5_cur));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_grant_ctrl.md
ARB_GRANT_CTRL -- requirements
Module: arb_grant_ctrl

Interface
REQ-001 The block SHALL have parameter ISIZE, default 8, meaning number of requesters (ISIZE >= 2).
REQ-002 The block SHALL have localparam IDXW, default $clog2(ISIZE), meaning width of grant index.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port reqs  input  ISIZE  request vector, bit i = requester i.
REQ-006 The block SHALL have port done  input  1  granted requester finished; releases grant.
REQ-007 The block SHALL have port gnts  output  ISIZE  registered one-hot grant, all-zero when idle.
REQ-008 The block SHALL have port gnt_vld  output  1  high while a grant is held.
REQ-009 The block SHALL have port gnt_idx  output  IDXW  binary index of set bit in gnts, 0 when idle.

Function
REQ-010 The block SHALL implement FSM states IDLE and GRANT only.
REQ-011 In IDLE with reqs==0, the block SHALL remain in IDLE with gnts=0, gnt_vld=0, gnt_idx=0.
REQ-012 In IDLE with reqs!=0 at edge N, the block SHALL enter GRANT and present the selected one-hot gnts, gnt_vld=1, matching gnt_idx after edge N (1-cycle latency).
REQ-013 Selection SHALL be round-robin: masked = reqs with bits below pointer ptr cleared; grant lowest set bit of masked if masked!=0, else lowest set bit of reqs.
REQ-014 ptr SHALL be an IDXW-bit register, reset 0, loaded with (gnt_idx+1) mod ISIZE when a grant is released.
REQ-015 In GRANT, gnts/gnt_idx SHALL stay stable irrespective of reqs (grant locks, even if granted request drops).
REQ-016 In GRANT with done=1 at an edge, the block SHALL return to IDLE, clear gnts/gnt_vld/gnt_idx, and update ptr on that edge; re-arbitration occurs from IDLE on the following edge (one bubble cycle between grants).
REQ-017 done SHALL be ignored in IDLE; ptr SHALL not change in IDLE.
REQ-018 gnts SHALL never have more than one bit set; gnt_vld SHALL equal |gnts.
REQ-019 ptr wrap SHALL be modulo ISIZE, correct for non-power-of-two ISIZE.

Reset
REQ-020 rst_n low SHALL asynchronously force state=IDLE, ptr=0, gnts=0, gnt_vld=0, gnt_idx=0, including mid-GRANT.
REQ-021 After rst_n deasserts, first arbitration SHALL occur on the first rising edge with reqs!=0.

Structure
REQ-022 The FSM state enum and a one-hot-to-index function SHALL reside in shared package arb_pkg.
REQ-023 Lowest-set-bit selection SHALL be done by two instances of existing sub-module arbiter (ISIZE-wide fixed-priority, combinational reqs->gnts), one on masked, one on raw reqs.
REQ-024 All outputs SHALL be driven directly from registers.

Verification
REQ-025 Reset: rst_n=0 with reqs=8'hFF -> gnts=8'h00, gnt_vld=0, gnt_idx=0.
REQ-026 reqs=8'h1F held, done pulsed one cycle per grant -> grant sequence 8'h01,8'h02,8'h04,8'h08,8'h10, each separated by one idle cycle, then 8'h01 again.
REQ-027 reqs=8'h3A from ptr=0, done each grant -> 8'h02,8'h08,8'h10,8'h20, then 8'h02 (wrap).
REQ-028 After grant idx4 (ptr=5), reqs=8'h0A -> gnts=8'h02, gnt_idx=1, then 8'h08 after done.
REQ-029 Lock: gnts=8'h04 held, reqs->8'h00, done=0 for 5 cycles -> gnts stays 8'h04, gnt_vld=1; done=1 -> gnts=8'h00 next edge.
REQ-030 rst_n=0 mid-GRANT (gnts=8'h08) -> outputs zero immediately, before next edge; after release, reqs=8'h08 -> gnts=8'h08 (ptr restarted at 0); done pulses in IDLE produce no change.
